// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C command arbiter.
// Holds the FSM state set, the 24-bit command word and slave addresses.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_END,
    CHECK,
    FINISH
  } state_t;

  typedef logic [23:0] word_t;

  localparam logic [7:0] SLV_AUDIO = 8'h34;
  localparam logic [7:0] SLV_VIDEO = 8'h40;

  // Round-robin pick: first set request after 'last', wrapping mod 3.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] last,
    input logic [2:0] r
  );
    logic [1:0] c;
    rr_pick = last;
    for (int k = 3; k >= 1; k--) begin
      c = 2'((32'(last) + k) % 3);
      if (r[c]) rr_pick = c;
    end
  endfunction

endpackage

// File: rtl/i2c_clk_div.sv
// Work-clock divider for the I2C controller.
// Toggles I2C_CTRL_CLK at terminal count; tick marks its rising edge.
module i2c_clk_div #(
  parameter int CLK_Freq = 50000000,
  parameter int I2C_Freq = 20000
) (
  input  logic clk,
  input  logic rst_n,
  output logic I2C_CTRL_CLK,
  output logic tick
);

  localparam int DIV = CLK_Freq / I2C_Freq;
  localparam int CW  = ($clog2(DIV + 1) < 1) ? 1 : $clog2(DIV + 1);

  logic [CW-1:0] cnt;
  logic          term;

  assign term = (cnt == CW'(DIV));
  assign tick = term & ~I2C_CTRL_CLK;

  // Count to terminal, then wrap and flip the work clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      I2C_CTRL_CLK <= 1'b0;
    end else if (term) begin
      cnt          <= '0;
      I2C_CTRL_CLK <= ~I2C_CTRL_CLK;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Three-way round-robin arbiter in front of one I2C command controller.
// Retries NACKed or timed-out transfers and reports done/err per requester.
module i2c_cmd_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int CLK_Freq      = 50000000,
  parameter int I2C_Freq      = 20000,
  parameter int MAX_RETRY     = 3,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic        CLOCK_50,
  input  logic        iRST_N,
  input  logic [2:0]  req,
  input  logic [71:0] req_data,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic        busy,
  output logic        I2C_CTRL_CLK,
  output logic [23:0] I2C_DATA,
  output logic        I2C_GO,
  input  logic        I2C_END,
  input  logic        I2C_ACK
);

  localparam int RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = ($clog2(TIMEOUT_TICKS + 1) < 1) ? 1 : $clog2(TIMEOUT_TICKS + 1);

  state_t        state;
  word_t         word;
  logic [1:0]    last;
  logic [1:0]    pick;
  logic [RW-1:0] retry;
  logic [TW-1:0] tcnt;
  logic          end_armed;
  logic          timed_out;
  logic          fin_err;
  logic          tick;

  i2c_clk_div #(
    .CLK_Freq(CLK_Freq),
    .I2C_Freq(I2C_Freq)
  ) u_div (
    .clk         (CLOCK_50),
    .rst_n       (iRST_N),
    .I2C_CTRL_CLK(I2C_CTRL_CLK),
    .tick        (tick)
  );

  assign pick = rr_pick(last, req);
  assign busy = (state != IDLE);

  // Arbitration and transfer sequencing, advanced only on work-clock ticks.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= IDLE;
      word      <= '0;
      last      <= 2'd2;
      retry     <= '0;
      tcnt      <= '0;
      end_armed <= 1'b0;
      timed_out <= 1'b0;
      fin_err   <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      I2C_DATA  <= '0;
      I2C_GO    <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (|req) begin
              gnt   <= 3'b001 << pick;
              word  <= req_data[24*pick +: 24];
              last  <= pick;
              retry <= '0;
              state <= LOAD;
            end
          end
          LOAD: begin
            I2C_DATA  <= word;
            I2C_GO    <= 1'b1;
            tcnt      <= '0;
            end_armed <= 1'b0;
            timed_out <= 1'b0;
            state     <= WAIT_END;
          end
          WAIT_END: begin
            tcnt <= tcnt + 1'b1;
            if (!I2C_END) end_armed <= 1'b1;
            if (end_armed && I2C_END) begin
              I2C_GO <= 1'b0;
              state  <= CHECK;
            end else if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
              I2C_GO    <= 1'b0;
              timed_out <= 1'b1;
              state     <= CHECK;
            end
          end
          CHECK: begin
            if (!I2C_ACK && !timed_out) begin
              fin_err <= 1'b0;
              state   <= FINISH;
            end else if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              state <= LOAD;
            end else begin
              fin_err <= 1'b1;
              state   <= FINISH;
            end
          end
          FINISH: begin
            done  <= gnt;
            err   <= fin_err ? gnt : 3'b000;
            gnt   <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
